// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin writeback arbiter (ALU / load) feeding an in-order pending-write FIFO.
// Latency: handshake at edge E, empty FIFO, no hold -> wb_en high during the cycle after edge E+1.
// Backpressure: only the granted producer sees ready, and only with FIFO space (a full FIFO frees a slot when it pops).
// Optional feature macro: WB_FWD_EN (forwarding of pending write data through fwd_src/fwd_hit/fwd_val).
module wb_arbiter #(
  parameter int N                 = 32,
  parameter int REG_FILE_ADDR_LEN = 5,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              alu_valid,
  output logic                              alu_ready,
  input  logic [REG_FILE_ADDR_LEN-1:0]      alu_dest,
  input  logic [N-1:0]                      alu_val,
  input  logic                              ld_valid,
  output logic                              ld_ready,
  input  logic [REG_FILE_ADDR_LEN-1:0]      ld_dest,
  input  logic [N-1:0]                      ld_val,
  input  logic                              wb_hold,
  output logic                              wb_en,
  output logic [REG_FILE_ADDR_LEN-1:0]      wb_dest,
  output logic [N-1:0]                      wb_val,
  output logic [2**REG_FILE_ADDR_LEN-1:0]   busy_mask,
  output logic [$clog2(FIFO_DEPTH):0]       count,
  input  logic [REG_FILE_ADDR_LEN-1:0]      fwd_src,
  output logic                              fwd_hit,
  output logic [N-1:0]                      fwd_val
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int NREG = 2**REG_FILE_ADDR_LEN;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_LD  = 1'b1
  } grant_e;

  typedef struct packed {
    logic [REG_FILE_ADDR_LEN-1:0] dest;
    logic [N-1:0]                 val;
  } entry_t;

  // Arbitration state and handshake qualifiers
  grant_e               last_grant_q, last_grant_d;
  grant_e               cand;
  entry_t               cand_ent;
  logic                 hs;
  logic                 push;
  logic                 pop_now;
  logic                 space;

  // Pending-write queue; occ_q marks live slots so the mask/forward logic can scan them
  entry_t               mem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] occ_q, occ_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;

  // Registered write port
  logic                 wb_en_q, wb_en_d;
  entry_t               wb_q, wb_d;

  logic [NREG-1:0]      busy_c;

  // Queue can take an entry if not full, or if the head leaves on this same edge
  always_comb begin
    pop_now = (count_q != '0) && !wb_hold;
    space   = (count_q < DEPTH_C) || pop_now;
  end

  // Round-robin candidate selection: with both offering, favour the one not granted last
  always_comb begin
    cand = GNT_ALU;
    if (alu_valid && ld_valid) begin
      cand = (last_grant_q == GNT_ALU) ? GNT_LD : GNT_ALU;
    end else if (ld_valid) begin
      cand = GNT_LD;
    end
    cand_ent.dest = (cand == GNT_LD) ? ld_dest : alu_dest;
    cand_ent.val  = (cand == GNT_LD) ? ld_val  : alu_val;
  end

  // Readies, handshake, enqueue decision; r0 writes are swallowed but still complete
  always_comb begin
    alu_ready    = !rst && alu_valid && (cand == GNT_ALU) && space;
    ld_ready     = !rst && ld_valid  && (cand == GNT_LD)  && space;
    hs           = alu_ready || ld_ready;
    push         = hs && (cand_ent.dest != '0);
    last_grant_d = hs ? cand : last_grant_q;
  end

  // Queue pointer / occupancy / count and write-port next state
  always_comb begin
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wb_en_d  = pop_now;
    wb_d     = wb_q;
    if (pop_now) begin
      occ_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + AW'(1);
      wb_d            = mem_q[rd_ptr_q];
    end
    // On a full-queue push+pop the pointers coincide, so the set must come after the clear
    if (push) begin
      occ_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    case ({push, pop_now})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= GNT_ALU;
      occ_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      wb_en_q      <= 1'b0;
      wb_q         <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      occ_q        <= occ_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      wb_en_q      <= wb_en_d;
      wb_q         <= wb_d;
    end
  end

  // Queue storage; contents are only meaningful where occ_q is set, so no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= cand_ent;
    end
  end

  // Pending-write mask from live queue slots plus the register currently on the write port
  always_comb begin
    busy_c = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (occ_q[i]) begin
        busy_c[mem_q[i].dest] = 1'b1;
      end
    end
    if (wb_en_q) begin
      busy_c[wb_q.dest] = 1'b1;
    end
    busy_c[0] = 1'b0;
  end

`ifdef WB_FWD_EN
  logic [AW-1:0] fwd_idx;

  // Youngest match wins: start at the write port, then walk the queue oldest to newest
  always_comb begin
    fwd_hit = 1'b0;
    fwd_val = '0;
    fwd_idx = '0;
    if (fwd_src != '0) begin
      if (wb_en_q && (wb_q.dest == fwd_src)) begin
        fwd_hit = 1'b1;
        fwd_val = wb_q.val;
      end
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        fwd_idx = rd_ptr_q + AW'(k);
        if (occ_q[fwd_idx] && (mem_q[fwd_idx].dest == fwd_src)) begin
          fwd_hit = 1'b1;
          fwd_val = mem_q[fwd_idx].val;
        end
      end
    end
  end
`else
  logic fwd_src_unused;

  // Forwarding disabled: lookup port is tied off
  always_comb begin
    fwd_src_unused = ^fwd_src;
    fwd_hit        = 1'b0;
    fwd_val        = '0;
  end
`endif

  assign wb_en     = wb_en_q;
  assign wb_dest   = wb_q.dest;
  assign wb_val    = wb_q.val;
  assign busy_mask = busy_c;
  assign count     = count_q;

endmodule
